// File: rtl/az_ctrl_seq.sv
// az_ctrl_seq -- instruction sequencer for the AZ10 stack processor.
//
// Each instruction is fetched at the current PC value and its 4-bit opcode
// is decoded. The block then drives control_bus and runs the stack/ALU
// handshakes. Finally it pulses pc_en and waits out the PC latency before
// the next fetch. All outputs are registered. The block is the only master
// of control_bus.
//
// Ports:
//   clk          single clock, rising edge
//   rstn         synchronous active-low reset
//   start        leave IDLE and begin execution
//   pc           current PC value
//   imem_addr    instruction memory address (memory has 1-cycle read latency)
//   imem_data    instruction word {opcode[3:0], immediate[DATA_LEN-1:0]}
//   control_bus  decoded opcode, DECODE through WAIT, else 0
//   pc_en        one-cycle PC advance strobe
//   stk_req      stack request; stk_push selects push(1)/pop(0)
//   stk_wdata    push data (immediate)
//   stk_ack      stack operation done
//   stk_full     stack status, sampled in DECODE
//   stk_empty    stack status, sampled in DECODE
//   alu_go       ALU start request
//   alu_done     ALU operation complete
//   busy         high in every state except IDLE and HALTED
//   halted       high in HALTED
//   err          sticky error flag, cleared only by reset
module az_ctrl_seq #(
  parameter int INST_CAP = 20,
  parameter int DATA_LEN = 8,
  parameter int TIMEOUT  = 15
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [$clog2(INST_CAP):0]  pc,
  output logic [$clog2(INST_CAP):0]  imem_addr,
  input  logic [DATA_LEN+3:0]        imem_data,
  output logic [3:0]                 control_bus,
  output logic                       pc_en,
  output logic                       stk_req,
  output logic                       stk_push,
  output logic [DATA_LEN-1:0]        stk_wdata,
  input  logic                       stk_ack,
  input  logic                       stk_full,
  input  logic                       stk_empty,
  output logic                       alu_go,
  input  logic                       alu_done,
  output logic                       busy,
  output logic                       halted,
  output logic                       err
);

  localparam int IW    = DATA_LEN + 4;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PUSH = 4'd1;
  localparam logic [3:0] OP_POP  = 4'd2;
  localparam logic [3:0] OP_JMP  = 4'd3;
  localparam logic [3:0] OP_JZ   = 4'd4;
  localparam logic [3:0] OP_JS   = 4'd5;
  localparam logic [3:0] OP_ADD  = 4'd6;
  localparam logic [3:0] OP_SUB  = 4'd7;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_ADV    = 3'd5,
    S_WAIT   = 3'd6,
    S_HALTED = 3'd7
  } state_t;

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_JMP) || (op == OP_JZ) || (op == OP_JS);
  endfunction

  function automatic logic is_stack_op(input logic [3:0] op);
    return (op == OP_PUSH) || (op == OP_POP);
  endfunction

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  state_t               state_r;
  logic [IW-1:0]        ir_r;
  logic [CNT_W-1:0]     wait_cnt_r;
  logic                 wait_extra_r;  // one more WAIT cycle still owed (branches)

  logic [3:0]           op_s;
  logic [DATA_LEN-1:0]  imm_s;
  logic                 exec_done_s;

  assign op_s  = ir_r[IW-1:DATA_LEN];
  assign imm_s = ir_r[DATA_LEN-1:0];

  // Select the completion handshake that belongs to the instruction in EXEC.
  always_comb begin
    exec_done_s = 1'b0;
    if (is_stack_op(op_s)) begin
      exec_done_s = stk_ack;
    end else begin
      exec_done_s = alu_done;
    end
  end

  // Sequencer FSM; every output is registered together with the state it belongs to.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r      <= S_IDLE;
      ir_r         <= '0;
      wait_cnt_r   <= '0;
      wait_extra_r <= 1'b0;
      imem_addr    <= '0;
      control_bus  <= 4'd0;
      pc_en        <= 1'b0;
      stk_req      <= 1'b0;
      stk_push     <= 1'b0;
      stk_wdata    <= '0;
      alu_go       <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      err          <= 1'b0;
    end else begin
      pc_en <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            // Address goes out on FETCH entry so the word is ready in LOAD.
            imem_addr <= pc;
            busy      <= 1'b1;
            state_r   <= S_FETCH;
          end
        end

        S_FETCH: begin
          state_r <= S_LOAD;
        end

        S_LOAD: begin
          ir_r        <= imem_data;
          control_bus <= imem_data[IW-1:DATA_LEN];
          state_r     <= S_DECODE;
        end

        S_DECODE: begin
          if (((op_s == OP_PUSH) && stk_full) ||
              (((op_s == OP_POP) || is_branch(op_s)) && stk_empty)) begin
            err         <= 1'b1;
            halted      <= 1'b1;
            busy        <= 1'b0;
            control_bus <= 4'd0;
            state_r     <= S_HALTED;
          end else if (op_s == OP_HALT) begin
            halted      <= 1'b1;
            busy        <= 1'b0;
            control_bus <= 4'd0;
            state_r     <= S_HALTED;
          end else if (is_stack_op(op_s)) begin
            stk_req    <= 1'b1;
            stk_push   <= (op_s == OP_PUSH);
            stk_wdata  <= imm_s;
            wait_cnt_r <= '0;
            state_r    <= S_EXEC;
          end else if (is_alu_op(op_s)) begin
            alu_go     <= 1'b1;
            wait_cnt_r <= '0;
            state_r    <= S_EXEC;
          end else begin
            // NOP, branches and reserved opcodes go straight to the PC strobe.
            wait_extra_r <= is_branch(op_s);
            pc_en        <= 1'b1;
            state_r      <= S_ADV;
          end
        end

        S_EXEC: begin
          if (exec_done_s) begin
            stk_req      <= 1'b0;
            alu_go       <= 1'b0;
            wait_extra_r <= 1'b0;
            pc_en        <= 1'b1;
            state_r      <= S_ADV;
          end else if (wait_cnt_r == CNT_LAST) begin
            stk_req     <= 1'b0;
            alu_go      <= 1'b0;
            err         <= 1'b1;
            halted      <= 1'b1;
            busy        <= 1'b0;
            control_bus <= 4'd0;
            state_r     <= S_HALTED;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_ONE;
          end
        end

        S_ADV: begin
          state_r <= S_WAIT;
        end

        S_WAIT: begin
          if (wait_extra_r) begin
            wait_extra_r <= 1'b0;
          end else begin
            imem_addr   <= pc;
            control_bus <= 4'd0;
            state_r     <= S_FETCH;
          end
        end

        S_HALTED: begin
          state_r <= S_HALTED;
        end

        default: begin
          // Unreachable encoding: fall back to a quiet IDLE.
          state_r     <= S_IDLE;
          control_bus <= 4'd0;
          stk_req     <= 1'b0;
          alu_go      <= 1'b0;
          busy        <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_az_ctrl_seq.sv
// Self-checking bench for az_ctrl_seq. It contains a behavioural instruction
// memory with 1-cycle read latency and a PC that increments on pc_en. The
// pc_en scoreboard holds the expected cycle of every strobe, and a monitor
// pops one entry per observed pc_en.
module tb_az_ctrl_seq;

  localparam int INST_CAP = 20;
  localparam int DATA_LEN = 8;
  localparam int TIMEOUT  = 15;
  localparam int PW       = $clog2(INST_CAP) + 1;

  logic                 clk;
  logic                 rstn;
  logic                 start;
  logic [PW-1:0]        pc;
  logic [PW-1:0]        imem_addr;
  logic [DATA_LEN+3:0]  imem_data;
  logic [3:0]           control_bus;
  logic                 pc_en;
  logic                 stk_req;
  logic                 stk_push;
  logic [DATA_LEN-1:0]  stk_wdata;
  logic                 stk_ack;
  logic                 stk_full;
  logic                 stk_empty;
  logic                 alu_go;
  logic                 alu_done;
  logic                 busy;
  logic                 halted;
  logic                 err;

  int total;
  int bad;
  int cyc;
  int f0;
  int sb[$];
  logic [DATA_LEN+3:0] mem [0:63];

  az_ctrl_seq #(.INST_CAP(INST_CAP), .DATA_LEN(DATA_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .start(start), .pc(pc), .imem_addr(imem_addr),
    .imem_data(imem_data), .control_bus(control_bus), .pc_en(pc_en),
    .stk_req(stk_req), .stk_push(stk_push), .stk_wdata(stk_wdata),
    .stk_ack(stk_ack), .stk_full(stk_full), .stk_empty(stk_empty),
    .alu_go(alu_go), .alu_done(alu_done), .busy(busy), .halted(halted), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory with one cycle of read latency.
  always @(posedge clk) imem_data <= mem[imem_addr];

  // Program counter model: advances by one on each strobe.
  always @(posedge clk) begin
    if (!rstn) pc <= '0;
    else if (pc_en) pc <= pc + 6'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Every pc_en pulse must match the next scheduled cycle.
  always @(negedge clk) begin
    if (rstn === 1'b1 && pc_en === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $error("FAIL pc_en_unexpected: got pulse at cycle %0d want none", cyc);
      end else begin
        int e;
        e = sb.pop_front();
        assert (cyc == e) else begin
          bad++;
          $error("FAIL pc_en_cycle: got %0d want %0d", cyc, e);
        end
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 12'h000;
  endtask

  task automatic do_reset(input string tag);
    rstn = 1'b0; start = 1'b0; stk_ack = 1'b0; alu_done = 1'b0;
    stk_full = 1'b0; stk_empty = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_busy"},   32'(busy), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_err"},    32'(err), 32'd0);
    chk({tag, "_pc_en"},  32'(pc_en), 32'd0);
    chk({tag, "_stk"},    32'({stk_req, stk_push, alu_go}), 32'd0);
    chk({tag, "_bus"},    32'(control_bus), 32'd0);
    chk({tag, "_addr"},   32'(imem_addr), 32'd0);
    chk({tag, "_wdata"},  32'(stk_wdata), 32'd0);
  endtask

  // Release reset with start high; f0 becomes the first FETCH cycle.
  task automatic launch();
    rstn = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    f0 = cyc;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    rstn = 1'b0; start = 1'b0; stk_ack = 1'b0; alu_done = 1'b0;
    stk_full = 1'b0; stk_empty = 1'b0;

    // ---- Run 1: NOP, reserved, PUSH with late ack, JZ, SUB, HALT ----
    clear_mem();
    mem[0] = 12'h000;  // NOP
    mem[1] = 12'h900;  // reserved -> NOP
    mem[2] = 12'h1A5;  // PUSH 0xA5
    mem[3] = 12'h400;  // JZ
    mem[4] = 12'h700;  // SUB
    mem[5] = 12'hF00;  // HALT
    do_reset("rst1");
    launch();
    chk("fetch0_busy", 32'(busy), 32'd1);
    chk("fetch0_addr", 32'(imem_addr), 32'd0);
    sb.push_back(f0 + 3);   // NOP
    sb.push_back(f0 + 8);   // reserved
    sb.push_back(f0 + 16);  // PUSH, 3 EXEC cycles
    sb.push_back(f0 + 21);  // JZ
    sb.push_back(f0 + 28);  // SUB, 1 EXEC cycle

    wait_cyc(f0 + 2);
    chk("nop_bus", 32'(control_bus), 32'd0);
    chk("nop_busy", 32'(busy), 32'd1);
    wait_cyc(f0 + 5);
    chk("fetch1_addr", 32'(imem_addr), 32'd1);
    wait_cyc(f0 + 7);
    chk("rsv_bus", 32'(control_bus), 32'd9);
    wait_cyc(f0 + 10);
    chk("fetch2_addr", 32'(imem_addr), 32'd2);
    chk("fetch2_bus", 32'(control_bus), 32'd0);
    wait_cyc(f0 + 12);
    stk_ack = 1'b1;   // ack in DECODE must be ignored
    chk("push_dec_bus", 32'(control_bus), 32'd1);
    wait_cyc(f0 + 13);
    stk_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_cyc(f0 + 13 + k);
      chk("push_req", 32'(stk_req), 32'd1);
      chk("push_dir", 32'(stk_push), 32'd1);
      chk("push_data", 32'(stk_wdata), 32'hA5);
      chk("push_no_pcen", 32'(pc_en), 32'd0);
    end
    stk_ack = 1'b1;
    wait_cyc(f0 + 16);
    stk_ack = 1'b0;
    chk("push_adv_req", 32'(stk_req), 32'd0);
    chk("push_adv_pcen", 32'(pc_en), 32'd1);
    wait_cyc(f0 + 18);
    chk("fetch3_addr", 32'(imem_addr), 32'd3);
    for (int k = 0; k < 4; k++) begin
      wait_cyc(f0 + 20 + k);
      chk("jz_bus", 32'(control_bus), 32'd4);
    end
    wait_cyc(f0 + 24);
    chk("fetch4_bus", 32'(control_bus), 32'd0);
    chk("fetch4_addr", 32'(imem_addr), 32'd4);
    wait_cyc(f0 + 27);
    chk("sub_go", 32'(alu_go), 32'd1);
    chk("sub_bus", 32'(control_bus), 32'd7);
    alu_done = 1'b1;
    wait_cyc(f0 + 28);
    alu_done = 1'b0;
    chk("sub_go_drop", 32'(alu_go), 32'd0);
    wait_cyc(f0 + 30);
    chk("fetch5_addr", 32'(imem_addr), 32'd5);
    wait_cyc(f0 + 33);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_err", 32'(err), 32'd0);
    chk("halt_bus", 32'(control_bus), 32'd0);
    start = 1'b1;
    wait_cyc(f0 + 37);
    start = 1'b0;
    chk("halt_start_ign", 32'({halted, busy}), 32'b10);
    chk("halt_addr_hold", 32'(imem_addr), 32'd5);
    chk("run1_sb_empty", 32'(sb.size()), 32'd0);

    // ---- Run 2: POP on empty stack ----
    clear_mem();
    mem[0] = 12'h200;
    do_reset("rst2");
    stk_empty = 1'b1;
    launch();
    wait_cyc(f0 + 3);
    chk("pop_err", 32'(err), 32'd1);
    chk("pop_halted", 32'(halted), 32'd1);
    chk("pop_busy", 32'(busy), 32'd0);
    chk("pop_req", 32'(stk_req), 32'd0);
    wait_cyc(f0 + 10);   // monitor flags any stray pc_en
    chk("pop_err_hold", 32'(err), 32'd1);
    stk_empty = 1'b0;

    // ---- Run 3: ADD with alu_done never asserted ----
    clear_mem();
    mem[0] = 12'h600;
    do_reset("rst3");
    launch();
    for (int k = 0; k < TIMEOUT; k++) begin
      wait_cyc(f0 + 3 + k);
      chk("add_go_held", 32'({alu_go, err}), 32'b10);
    end
    wait_cyc(f0 + 3 + TIMEOUT);
    chk("add_to_go", 32'(alu_go), 32'd0);
    chk("add_to_err", 32'(err), 32'd1);
    chk("add_to_halted", 32'(halted), 32'd1);
    wait_cyc(f0 + 8 + TIMEOUT);
    chk("run3_sb_empty", 32'(sb.size()), 32'd0);

    // ---- Run 4: reset while stk_req is high ----
    clear_mem();
    mem[0] = 12'h13C;
    do_reset("rst4");
    launch();
    wait_cyc(f0 + 3);
    chk("mid_req", 32'(stk_req), 32'd1);
    chk("mid_data", 32'(stk_wdata), 32'h3C);
    wait_cyc(f0 + 4);
    rstn = 1'b0;
    wait_cyc(f0 + 5);
    chk("mid_rst_req", 32'({stk_req, stk_push, alu_go, pc_en}), 32'd0);
    chk("mid_rst_stat", 32'({busy, halted, err}), 32'd0);
    chk("mid_rst_bus", 32'(control_bus), 32'd0);
    chk("mid_rst_wdata", 32'(stk_wdata), 32'd0);
    rstn = 1'b1;
    wait_cyc(f0 + 8);
    chk("idle_after_rst", 32'({busy, stk_req, halted}), 32'd0);
    chk("idle_addr", 32'(imem_addr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/az_ctrl_seq.md
# az_ctrl_seq

Instruction sequencer for the AZ10 stack processor. It fetches each instruction word at the current program-counter value and decodes its 4-bit opcode. It then drives the shared `control_bus` and sequences the operand stack and the ALU through request/acknowledge handshakes. Finally it pulses the PC enable and waits out the PC's fixed internal latency before the next fetch. It sits between instruction memory, the PC, the stack and the ALU, and is the only master of `control_bus`.

## Interface
- `INST_CAP`, 20: instruction memory depth; PC width is `$clog2(INST_CAP)+1`.
- `DATA_LEN`, 8: data/immediate width; instruction word is `DATA_LEN+4` bits, `[DATA_LEN+3:DATA_LEN]` = opcode, `[DATA_LEN-1:0]` = immediate.
- `TIMEOUT`, 15: maximum EXEC wait cycles before error.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `start`  in  1  leave IDLE and begin execution.
- `pc`  in  `$clog2(INST_CAP)+1`  current PC value.
- `imem_addr`  out  `$clog2(INST_CAP)+1`  instruction memory address (memory has 1-cycle read latency).
- `imem_data`  in  `DATA_LEN+4`  instruction word.
- `control_bus`  out  4  decoded opcode to PC/ALU.
- `pc_en`  out  1  one-cycle PC advance strobe.
- `stk_req`  out  1  stack operation request.
- `stk_push`  out  1  1 = push, 0 = pop (valid with `stk_req`).
- `stk_wdata`  out  `DATA_LEN`  push data (immediate).
- `stk_ack`  in  1  stack operation done.
- `stk_full`, `stk_empty`  in  1 each  stack status.
- `alu_go`  out  1  ALU start request.
- `alu_done`  in  1  ALU operation complete.
- `busy`, `halted`, `err`  out  1 each  status.

## Operation
- Opcodes:
  - 0 NOP.
  - 1 PUSH imm.
  - 2 POP.
  - 3 JMP, 4 JZ, 5 JS: branch; the PC pops the target itself.
  - 6 ADD, 7 SUB: ALU ops.
  - 8–14: reserved, executed as NOP.
  - 15 HALT.
- States: IDLE, FETCH, LOAD, DECODE, EXEC, ADV, WAIT, HALTED.
- IDLE → FETCH when `start`=1. FETCH: `imem_addr` ← `pc`. LOAD: instruction register ← `imem_data`.
- DECODE transitions:
  - Error checks: PUSH with `stk_full`=1 → HALTED with `err`; POP or branch with `stk_empty`=1 → HALTED with `err`.
  - HALT → HALTED.
  - PUSH/POP/ADD/SUB → EXEC.
  - All other opcodes → ADV.
- EXEC for stack ops:
  - `stk_req`=1 and `stk_push`/`stk_wdata` are held stable until `stk_ack` is sampled high, then → ADV.
- EXEC for ALU ops:
  - `alu_go`=1 is held until `alu_done` is sampled high, then → ADV.
- EXEC timeout:
  - A wait counter starts at 0 on EXEC entry.
  - If the ack/done signal has not arrived after `TIMEOUT` cycles, → HALTED with `err`=1; `stk_req`/`alu_go` drop.
- ADV: `pc_en`=1 for exactly one cycle → WAIT.
- WAIT: hold for 1 cycle (non-branch) or 2 cycles (opcodes 3–5), then → FETCH.
- `control_bus` = instruction-register opcode from DECODE through the end of WAIT; 0 in all other states. The PC samples it during its branch-resolve cycle.
- HALTED: absorbing; only `rstn` exits. `halted`=1; `err` keeps its value.
- `busy`=1 in every state except IDLE and HALTED.

## Timing
- Reset (`rstn`=0 at a rising edge) from any state, including mid-EXEC:
  - State → IDLE.
  - `pc_en`, `stk_req`, `stk_push`, `alu_go`, `busy`, `halted`, `err` = 0.
  - `control_bus` = 0, `imem_addr` = 0, `stk_wdata` = 0.
  - Holding `pc_en`=0 during reset guarantees the PC sees en=0 and resets too.
- Cycles from FETCH to the next FETCH:
  - NOP/reserved: 5.
  - Branch: 6.
  - PUSH/POP/ALU: 6 + (cycles waiting for ack/done); ack in the first EXEC cycle gives 6.
- `start` is ignored outside IDLE. `stk_ack`/`alu_done` are ignored outside EXEC.
- `stk_full`/`stk_empty` are sampled only in DECODE.

## Test plan
- **NOP flow:**
  - Stimulus: reset, `start`=1, program all NOP.
  - Required: `pc_en` pulses every 5 cycles; `control_bus`=0; `busy`=1.
- **PUSH with delayed ack:**
  - Stimulus: PUSH 0xA5, `stk_ack` after 3 cycles.
  - Required: `stk_req`=1, `stk_push`=1, `stk_wdata`=0xA5 held 3 cycles; `pc_en` 1 cycle after ack; 8 cycles FETCH→FETCH.
- **JZ:**
  - Stimulus: JZ with `stk_empty`=0.
  - Required: `control_bus`=4 from DECODE through 2 WAIT cycles; next FETCH 6 cycles later.
- **Error cases:**
  - Stimulus: POP with `stk_empty`=1; separately, ADD with `alu_done` never asserted.
  - Required: POP → HALTED, `err`=1, no `pc_en`. ADD → `err`=1 after 15 EXEC cycles, `alu_go` drops.
- **HALT, then reset mid-EXEC:**
  - Stimulus: HALT opcode; then `rstn`=0 while `stk_req`=1.
  - Required: HALT gives `halted`=1, `busy`=0, `start` ignored. Reset gives all outputs 0 and IDLE the next cycle.
